// File: rtl/segment_scheduler_pkg.sv
// Shared types and constants for the segment scheduler: opcodes, record
// field layout, FSM state encoding and opcode classification.
package segment_scheduler_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MOVE  = 8'h01;
  localparam logic [7:0] OP_DWELL = 8'h02;
  localparam logic [7:0] OP_END   = 8'hFF;

  localparam int OP_LSB     = 0;
  localparam int OP_W       = 8;
  localparam int DIR_LSB    = 8;
  localparam int DIR_W      = 8;
  localparam int COUNT_LSB  = 16;
  localparam int COUNT_W    = 32;
  localparam int PERIOD_LSB = 48;
  localparam int PERIOD_W   = 32;
  localparam int REC_USED_W = 80;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_REC, DISPATCH, WAIT_EXEC, HALT, DRAIN
  } sched_state_t;

  typedef enum logic [2:0] {
    OPC_NOP, OPC_MOVE, OPC_DWELL, OPC_END, OPC_BAD
  } op_class_t;

  function automatic op_class_t classify_op(input logic [7:0] op);
    case (op)
      OP_NOP:   return OPC_NOP;
      OP_MOVE:  return OPC_MOVE;
      OP_DWELL: return OPC_DWELL;
      OP_END:   return OPC_END;
      default:  return OPC_BAD;
    endcase
  endfunction

endpackage

// File: rtl/segment_scheduler_if.sv
// Record-Fifo read side and step-executor handshake, bundled for the scheduler.
interface segment_scheduler_if #(
  parameter int RECORD_SIZE_BYTES = 16
);
  logic                           fifo_available;
  logic                           fifo_request;
  logic                           fifo_record_ready;
  logic [RECORD_SIZE_BYTES*8-1:0] fifo_record;
  logic                           exec_load;
  logic                           exec_dwell;
  logic [7:0]                     exec_dir;
  logic [31:0]                    exec_count;
  logic [31:0]                    exec_period;
  logic                           exec_abort;
  logic                           exec_busy;

  modport master (
    input  fifo_available, fifo_record_ready, fifo_record, exec_busy,
    output fifo_request, exec_load, exec_dwell, exec_dir, exec_count,
           exec_period, exec_abort
  );

  modport slave (
    output fifo_available, fifo_record_ready, fifo_record, exec_busy,
    input  fifo_request, exec_load, exec_dwell, exec_dir, exec_count,
           exec_period, exec_abort
  );
endinterface

// File: rtl/segment_scheduler_decoder.sv
// Combinational record decoder: splits a raw Fifo record into opcode class
// and segment fields. Bytes above the used field area are ignored.
module segment_decoder
  import segment_scheduler_pkg::*;
#(
  parameter int REC_W = 128
) (
  input  logic [REC_W-1:0] record,
  output op_class_t        op_class,
  output logic [7:0]       dir,
  output logic [31:0]      count,
  output logic [31:0]      period
);

  assign op_class = classify_op(record[OP_LSB +: OP_W]);
  assign dir      = record[DIR_LSB +: DIR_W];
  assign count    = record[COUNT_LSB +: COUNT_W];
  assign period   = record[PERIOD_LSB +: PERIOD_W];

  generate
    if (REC_W > REC_USED_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^record[REC_W-1:REC_USED_W];
    end
  endgenerate

endmodule

// File: rtl/segment_scheduler.sv
// Pulls motion records from the record Fifo, decodes them and hands
// MOVE/DWELL segments to the step executor; keeps host-visible status.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | parked; waits for enable
// FETCH     | requests next record when the Fifo has one
// WAIT_REC  | request issued; waits for record_ready
// DISPATCH  | acts on the latched opcode (exec_load is high here)
// WAIT_EXEC | executor running; waits for busy to rise then fall
// HALT      | unknown opcode seen; only abort or reset leaves
// DRAIN     | aborted mid-request; swallows the pending record
module segment_scheduler
  import segment_scheduler_pkg::*;
#(
  parameter int RECORD_SIZE_BYTES = 16,
  parameter int SEG_CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 abort,
  segment_scheduler_if.master  bus,
  output logic                 idle,
  output logic                 job_done,
  output logic                 underrun,
  output logic                 bad_opcode,
  output logic [SEG_CNT_W-1:0] seg_count
);

  sched_state_t         state_q, state_d;
  op_class_t            rec_op_q, rec_op_d, dec_op;
  logic                 rec_zero_q, rec_zero_d;
  logic                 in_job_q, in_job_d, seen_busy_q, seen_busy_d;
  logic                 underrun_q, underrun_d, bad_opcode_q, bad_opcode_d;
  logic                 fifo_request_q, fifo_request_d, job_done_q, job_done_d;
  logic                 exec_load_q, exec_load_d, exec_abort_q, exec_abort_d;
  logic                 exec_dwell_q, exec_dwell_d;
  logic [7:0]           exec_dir_q, exec_dir_d, dec_dir;
  logic [31:0]          exec_count_q, exec_count_d, dec_count;
  logic [31:0]          exec_period_q, exec_period_d, dec_period;
  logic [SEG_CNT_W-1:0] seg_count_q, seg_count_d;
  logic                 dec_is_seg;

  segment_decoder #(.REC_W(RECORD_SIZE_BYTES*8)) u_dec (
    .record   (bus.fifo_record),
    .op_class (dec_op),
    .dir      (dec_dir),
    .count    (dec_count),
    .period   (dec_period)
  );

  // The load decision is taken as the record arrives so exec_load is high
  // in the DISPATCH cycle, one cycle after record_ready.
  assign dec_is_seg = ((dec_op == OPC_MOVE) || (dec_op == OPC_DWELL)) && (dec_count != 32'd0);

  // Next-state and registered-output logic; abort outranks everything but DRAIN.
  always_comb begin
    state_d        = state_q;
    rec_op_d       = rec_op_q;
    rec_zero_d     = rec_zero_q;
    in_job_d       = in_job_q;
    seen_busy_d    = seen_busy_q;
    underrun_d     = underrun_q;
    bad_opcode_d   = bad_opcode_q;
    seg_count_d    = seg_count_q;
    exec_dwell_d   = exec_dwell_q;
    exec_dir_d     = exec_dir_q;
    exec_count_d   = exec_count_q;
    exec_period_d  = exec_period_q;
    fifo_request_d = 1'b0;
    job_done_d     = 1'b0;
    exec_load_d    = 1'b0;
    exec_abort_d   = 1'b0;

    if (abort && (state_q != DRAIN)) begin
      exec_abort_d = 1'b1;
      in_job_d     = 1'b0;
      seen_busy_d  = 1'b0;
      underrun_d   = 1'b0;
      bad_opcode_d = 1'b0;
      // A record arriving in the abort cycle is already consumed; no drain needed.
      state_d      = (state_q == WAIT_REC && !bus.fifo_record_ready) ? DRAIN : IDLE;
    end else begin
      case (state_q)
        IDLE: if (enable) state_d = FETCH;
        FETCH: begin
          if (!enable) state_d = IDLE;
          else if (bus.fifo_available) begin
            fifo_request_d = 1'b1;
            state_d        = WAIT_REC;
          end else if (in_job_q) underrun_d = 1'b1;
        end
        WAIT_REC: begin
          if (bus.fifo_record_ready) begin
            rec_op_d   = dec_op;
            rec_zero_d = (dec_count == 32'd0);
            job_done_d = (dec_op == OPC_END);
            state_d    = DISPATCH;
            if (dec_is_seg) begin
              exec_load_d   = 1'b1;
              exec_dwell_d  = (dec_op == OPC_DWELL);
              exec_dir_d    = dec_dir;
              exec_count_d  = dec_count;
              exec_period_d = dec_period;
            end
          end
        end
        DISPATCH: begin
          case (rec_op_q)
            OPC_NOP: state_d = FETCH;
            OPC_END: begin
              in_job_d = 1'b0;
              state_d  = IDLE;
            end
            OPC_BAD: begin
              bad_opcode_d = 1'b1;
              state_d      = HALT;
            end
            default: begin
              if (rec_zero_q) begin
                seg_count_d = seg_count_q + SEG_CNT_W'(1);
                state_d     = FETCH;
              end else begin
                in_job_d = 1'b1;
                state_d  = WAIT_EXEC;
              end
            end
          endcase
        end
        WAIT_EXEC: begin
          if (bus.exec_busy) seen_busy_d = 1'b1;
          else if (seen_busy_q) begin
            seg_count_d = seg_count_q + SEG_CNT_W'(1);
            seen_busy_d = 1'b0;
            state_d     = enable ? FETCH : IDLE;
          end
        end
        HALT: state_d = HALT;
        DRAIN: if (bus.fifo_record_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rec_op_q       <= OPC_NOP;
      rec_zero_q     <= 1'b0;
      in_job_q       <= 1'b0;
      seen_busy_q    <= 1'b0;
      underrun_q     <= 1'b0;
      bad_opcode_q   <= 1'b0;
      seg_count_q    <= '0;
      fifo_request_q <= 1'b0;
      job_done_q     <= 1'b0;
      exec_load_q    <= 1'b0;
      exec_abort_q   <= 1'b0;
      exec_dwell_q   <= 1'b0;
      exec_dir_q     <= '0;
      exec_count_q   <= '0;
      exec_period_q  <= '0;
    end else begin
      state_q        <= state_d;
      rec_op_q       <= rec_op_d;
      rec_zero_q     <= rec_zero_d;
      in_job_q       <= in_job_d;
      seen_busy_q    <= seen_busy_d;
      underrun_q     <= underrun_d;
      bad_opcode_q   <= bad_opcode_d;
      seg_count_q    <= seg_count_d;
      fifo_request_q <= fifo_request_d;
      job_done_q     <= job_done_d;
      exec_load_q    <= exec_load_d;
      exec_abort_q   <= exec_abort_d;
      exec_dwell_q   <= exec_dwell_d;
      exec_dir_q     <= exec_dir_d;
      exec_count_q   <= exec_count_d;
      exec_period_q  <= exec_period_d;
    end
  end

  assign bus.fifo_request = fifo_request_q;
  assign bus.exec_load    = exec_load_q;
  assign bus.exec_abort   = exec_abort_q;
  assign bus.exec_dwell   = exec_dwell_q;
  assign bus.exec_dir     = exec_dir_q;
  assign bus.exec_count   = exec_count_q;
  assign bus.exec_period  = exec_period_q;
  assign idle             = (state_q == IDLE);
  assign job_done         = job_done_q;
  assign underrun         = underrun_q;
  assign bad_opcode       = bad_opcode_q;
  assign seg_count        = seg_count_q;

endmodule

// File: tb/tb_segment_scheduler.sv
`timescale 1ns/1ps
module tb_segment_scheduler;
  import segment_scheduler_pkg::*;

  localparam int RSB = 16;
  // Narrow counter so the wrap-around is reachable in a short run.
  localparam int SCW = 8;

  typedef struct packed {
    logic        dwell;
    logic [7:0]  dir;
    logic [31:0] count;
    logic [31:0] period;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n, enable, abort;
  logic           idle, job_done, underrun, bad_opcode;
  logic [SCW-1:0] seg_count;

  segment_scheduler_if #(.RECORD_SIZE_BYTES(RSB)) sif ();

  segment_scheduler #(.RECORD_SIZE_BYTES(RSB), .SEG_CNT_W(SCW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .abort      (abort),
    .bus        (sif),
    .idle       (idle),
    .job_done   (job_done),
    .underrun   (underrun),
    .bad_opcode (bad_opcode),
    .seg_count  (seg_count)
  );

  always #5 clk = ~clk;

  logic [RSB*8-1:0] rec_mem [512];
  int   wr_idx = 0, rd_idx = 0;
  exp_t exp_q[$];
  int   cyc = 0, rdy_cyc = -10;
  int   req_cnt = 0, load_cnt = 0, done_cnt = 0, xabort_cnt = 0;
  int   rdy_delay = 1, busy_len = 50;
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  assign sif.fifo_available = (wr_idx != rd_idx);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req_v);
    n_chk++;
    assert (obs === req_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req_v);
    end
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] dir,
                      input logic [31:0] count, input logic [31:0] period);
    logic [RSB*8-1:0] r;
    exp_t e;
    r = '0;
    r[7:0] = op;
    r[15:8] = dir;
    r[47:16] = count;
    r[79:48] = period;
    r[127:96] = 32'hDEAD_BEEF;
    rec_mem[wr_idx] = r;
    if ((op == 8'h01 || op == 8'h02) && count != 32'd0) begin
      e.dwell = (op == 8'h02);
      e.dir = dir;
      e.count = count;
      e.period = period;
      exp_q.push_back(e);
    end
    wr_idx++;
  endtask

  task automatic wait_seg(input int n, input int bound, input string tag);
    int k;
    k = 0;
    while (int'(seg_count) != n && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_reach"}, 64'(int'(seg_count) == n), 64'd1);
  endtask

  task automatic do_reset();
    enable = 1'b0;
    abort  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int l0, r0, d0, a0, k;
    exp_t e;
    sif.fifo_record_ready = 1'b0;
    sif.fifo_record = '0;
    sif.exec_busy = 1'b0;
    enable = 1'b0;
    abort = 1'b0;
    rst_n = 1'b0;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      // output monitor and scoreboard pop
      forever begin
        @(negedge clk);
        if (sif.fifo_record_ready) rdy_cyc = cyc;
        if (sif.fifo_request) req_cnt++;
        if (job_done) done_cnt++;
        if (sif.exec_abort) xabort_cnt++;
        if (sif.exec_load) begin
          load_cnt++;
          chk("load_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("load_dwell", 64'(sif.exec_dwell), 64'(e.dwell));
            chk("load_dir", 64'(sif.exec_dir), 64'(e.dir));
            chk("load_count", 64'(sif.exec_count), 64'(e.count));
            chk("load_period", 64'(sif.exec_period), 64'(e.period));
            chk("load_latency", 64'(cyc - rdy_cyc), 64'd1);
          end
        end
      end
      // record Fifo model
      forever begin
        @(negedge clk);
        if (sif.fifo_request) begin
          repeat (rdy_delay) @(posedge clk);
          #1;
          sif.fifo_record = rec_mem[rd_idx];
          rd_idx++;
          sif.fifo_record_ready = 1'b1;
          @(posedge clk);
          #1 sif.fifo_record_ready = 1'b0;
        end
      end
      // step executor model
      forever begin
        @(negedge clk);
        if (sif.exec_load) begin
          @(posedge clk);
          #1 sif.exec_busy = 1'b1;
          repeat (busy_len) @(posedge clk);
          #1 sif.exec_busy = 1'b0;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_seg_count", 64'(seg_count), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_bad_opcode", 64'(bad_opcode), 64'd0);
    chk("rst_job_done", 64'(job_done), 64'd0);
    chk("rst_exec_load", 64'(sif.exec_load), 64'd0);
    chk("rst_fifo_request", 64'(sif.fifo_request), 64'd0);
    chk("rst_exec_count", 64'(sif.exec_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // three MOVE segments with a slow executor
    busy_len = 50;
    rdy_delay = 1;
    l0 = load_cnt;
    for (int i = 0; i < 3; i++) push(OP_MOVE, 8'(8'h81 + i), 32'd5, 32'd10);
    enable = 1'b1;
    wait_seg(3, 400, "t1_seg");
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_loads", 64'(load_cnt - l0), 64'd3);
    chk("t1_seg_count", 64'(seg_count), 64'd3);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_count_hold", 64'(sif.exec_count), 64'd5);
    chk("t1_period_hold", 64'(sif.exec_period), 64'd10);
    chk("t1_idle", 64'(idle), 64'd1);

    // NOP then END
    do_reset();
    l0 = load_cnt;
    d0 = done_cnt;
    push(OP_NOP, 8'h00, 32'd7, 32'd7);
    push(OP_END, 8'h00, 32'd0, 32'd0);
    enable = 1'b1;
    k = 0;
    while (!job_done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t2_job_done", 64'(job_done), 64'd1);
    @(negedge clk);
    enable = 1'b0;
    chk("t2_idle", 64'(idle), 64'd1);
    chk("t2_done_pulse", 64'(job_done), 64'd0);
    repeat (2) @(negedge clk);
    chk("t2_no_load", 64'(load_cnt - l0), 64'd0);
    chk("t2_seg_count", 64'(seg_count), 64'd0);
    chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

    // underrun after a MOVE, then resume
    do_reset();
    busy_len = 6;
    push(OP_MOVE, 8'h03, 32'd4, 32'd2);
    enable = 1'b1;
    wait_seg(1, 100, "t3_first");
    r0 = req_cnt;
    repeat (20) @(negedge clk);
    chk("t3_underrun", 64'(underrun), 64'd1);
    chk("t3_not_idle", 64'(idle), 64'd0);
    chk("t3_no_req", 64'(req_cnt - r0), 64'd0);
    push(OP_DWELL, 8'h0C, 32'd2, 32'd7);
    wait_seg(2, 100, "t3_resume");
    chk("t3_underrun_sticky", 64'(underrun), 64'd1);
    chk("t3_one_req", 64'(req_cnt - r0), 64'd1);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // bad opcode -> HALT, then abort
    do_reset();
    rdy_delay = 1;
    push(8'h37, 8'h00, 32'd3, 32'd3);
    enable = 1'b1;
    k = 0;
    while (!bad_opcode && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t4_bad_opcode", 64'(bad_opcode), 64'd1);
    r0 = req_cnt;
    // left in the Fifo and later discarded by the drain step
    rec_mem[wr_idx] = 128'h0;
    rec_mem[wr_idx][7:0] = OP_MOVE;
    rec_mem[wr_idx][47:16] = 32'd9;
    wr_idx++;
    repeat (20) @(negedge clk);
    chk("t4_halt_no_req", 64'(req_cnt - r0), 64'd0);
    chk("t4_halt_not_idle", 64'(idle), 64'd0);
    enable = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_exec_abort", 64'(sif.exec_abort), 64'd1);
    chk("t4_bad_cleared", 64'(bad_opcode), 64'd0);
    chk("t4_idle", 64'(idle), 64'd1);
    @(negedge clk);
    chk("t4_abort_pulse", 64'(sif.exec_abort), 64'd0);

    // abort while waiting for a record
    rdy_delay = 4;
    l0 = load_cnt;
    a0 = xabort_cnt;
    enable = 1'b1;
    k = 0;
    while (!sif.fifo_request && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_request", 64'(sif.fifo_request), 64'd1);
    enable = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_exec_abort", 64'(sif.exec_abort), 64'd1);
    chk("t5_drain_not_idle", 64'(idle), 64'd0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_drain_abort_ignored", 64'(sif.exec_abort), 64'd0);
    k = 0;
    while (!sif.fifo_record_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_ready_seen", 64'(sif.fifo_record_ready), 64'd1);
    chk("t5_still_drain", 64'(idle), 64'd0);
    @(negedge clk);
    chk("t5_idle_after_drain", 64'(idle), 64'd1);
    repeat (3) @(negedge clk);
    chk("t5_no_load", 64'(load_cnt - l0), 64'd0);
    chk("t5_one_exec_abort", 64'(xabort_cnt - a0), 64'd1);
    chk("t5_record_consumed", 64'(rd_idx == wr_idx), 64'd1);

    // zero-count segments and counter wrap
    do_reset();
    rdy_delay = 1;
    busy_len = 3;
    l0 = load_cnt;
    push(OP_MOVE, 8'h00, 32'd0, 32'd4);
    enable = 1'b1;
    wait_seg(1, 50, "t6_zero");
    chk("t6_zero_no_load", 64'(load_cnt - l0), 64'd0);
    for (int i = 0; i < 254; i++)
      push((i % 2 == 0) ? OP_DWELL : OP_MOVE, 8'(i), 32'd0, 32'(i));
    wait_seg(255, 3000, "t6_preload");
    chk("t6_preload_no_load", 64'(load_cnt - l0), 64'd0);
    chk("t6_no_underrun", 64'(underrun), 64'd0);
    push(OP_DWELL, 8'h5A, 32'd3, 32'd9);
    k = 0;
    while (seg_count == 8'hFF && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_wrap", 64'(seg_count), 64'd0);
    chk("t6_one_load", 64'(load_cnt - l0), 64'd1);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
